serial_sub_unit: RTL
====================

Name: serial_sub_unit

Overview:
Bit-serial N-bit subtractor; computes diff = a - b, LSB first, one bit per clock.
Each bit uses a full-subtractor built from two half-subtractor cells plus an OR on the borrows.
It is the inverse arithmetic direction of the team's half-adder path and the next arithmetic block in the same datapath library.
Operands enter over a valid/ready input handshake; results leave over a valid/ready output handshake.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair a/b is valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend, unsigned
b  input  WIDTH  subtrahend, unsigned
out_valid  output  1  diff/borrow_out are valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  (a - b) mod 2^WIDTH
borrow_out  output  1  1 when a < b (unsigned)
busy  output  1  high in SHIFT state

Behaviour:
- One clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, diff=0, borrow_out=0, bit counter=0, internal borrow=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: load a_sr<=a, b_sr<=b, cnt<=0, brw<=0, go to SHIFT.
  - Operands are sampled only at this edge; later changes on a/b are ignored.
- SHIFT (in_ready=0, busy=1), every cycle:
  - d = a_sr[0]^b_sr[0]^brw.
  - nb = (~a_sr[0] & b_sr[0]) | (~(a_sr[0]^b_sr[0]) & brw).
  - diff_sr <= {d, diff_sr[WIDTH-1:1]}; a_sr and b_sr shift right by 1; brw <= nb; cnt <= cnt+1.
  - When cnt==WIDTH-1: go to DONE; at the same edge, diff <= final diff_sr value including this bit, and borrow_out <= nb.
- DONE:
  - out_valid=1; diff and borrow_out held stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - No direct DONE->SHIFT path; a new operand pair is accepted no earlier than the cycle after the output handshake.
- Latency: out_valid rises exactly WIDTH clock edges after the input-accept edge.
- Throughput: one result per WIDTH+2 cycles when out_ready is held high.
- in_valid during SHIFT/DONE: ignored (in_ready=0); the producer must hold its data.
- out_ready while not in DONE: no effect.
- Reset asserted mid-operation: immediate return to reset values. The partial result is discarded and no out_valid pulse occurs.
- Width rule: cnt is $clog2(WIDTH) bits wide; no wrap occurs because cnt clears on accept.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0).
  - Interprets a/b as two's complement.
  - ovf <= (a_msb != b_msb) && (d_msb != a_msb), captured at the final SHIFT edge.
  - Requires a_msb/b_msb latched at accept.
  - Valid and held with out_valid.
- Undefined: no ovf port, no MSB latches; behaviour otherwise identical.

Decomposition:
- Package serial_sub_pkg: state enum typedef (IDLE/SHIFT/DONE), default WIDTH constant.
- Sub-module half_sub_cell (combinational; x, y -> d = x^y, bo = ~x&y).
  - Instantiated twice to form the per-bit full subtractor.
  - Final borrow = bo1 | bo2.

Test Plan:
- WIDTH=8; a=5, b=3 -> after 8 cycles out_valid=1, diff=0x02, borrow_out=0.
- a=3, b=5 -> diff=0xFE, borrow_out=1. Then a=0x00, b=0x00 -> diff=0x00, borrow_out=0.
- a=0xFF, b=0x01, out_ready held 0 for 5 cycles after out_valid -> diff=0xFE stable and out_valid high throughout; releases one cycle after out_ready=1; in_ready=1 the next cycle.
- Accept a=0x10, b=0x01; drive in_valid=1 with a=0x55 during SHIFT -> ignored; result diff=0x0F.
- rst_n low at SHIFT cycle 3 -> out_valid=0, in_ready=1, diff=0 immediately (asynchronously); next op a=9, b=4 -> diff=0x05.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x10, b=0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
// Optional feature macro used by serial_sub_unit: SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  // Default operand/result width; legal range is 2..32.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states: wait for operands, shift one bit per clock, hold result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/half_sub_cell.sv
// half_sub_cell: combinational half subtractor, d = x - y with borrow out.
// Two of these plus an OR on the borrows form one full-subtractor bit.
module half_sub_cell (
  input  logic i_x,
  input  logic i_y,
  output logic o_d,
  output logic o_bo
);

  assign o_d  = i_x ^ i_y;
  assign o_bo = ~i_x & i_y;

endmodule

// File: rtl/serial_sub_unit.sv
// serial_sub_unit: bit-serial WIDTH-bit subtractor, diff = a - b, LSB first.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; the producer holds its data and valid until ready is seen.
// Optional feature: define SERIAL_SUB_OVF_EN to add the two's-complement
// overflow output ovf (captured with the final bit, held with out_valid).
module serial_sub_unit
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic [1:0]       o_dbg_state
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_diff_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_brw;

  logic             w_d1;
  logic             w_bo1;
  logic             w_d;
  logic             w_bo2;
  logic             w_nb;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic [WIDTH-1:0] w_diff_nx;

`ifdef SERIAL_SUB_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  // Per-bit full subtractor: (a - b) then minus the running borrow.
  half_sub_cell u_hs_ab (
    .i_x  (r_a_sr[0]),
    .i_y  (r_b_sr[0]),
    .o_d  (w_d1),
    .o_bo (w_bo1)
  );

  half_sub_cell u_hs_brw (
    .i_x  (w_d1),
    .i_y  (r_brw),
    .o_d  (w_d),
    .o_bo (w_bo2)
  );

  assign w_nb      = w_bo1 | w_bo2;
  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_shift   = (r_state == SHIFT);
  assign w_last    = w_shift && (r_cnt == LAST);
  // New bit enters at the top; after the last shift this is the whole result.
  assign w_diff_nx = {w_d, r_diff_sr};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake/status outputs decoded from the current state.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: load operands on accept, shift one bit per SHIFT cycle,
  // capture the result on the final bit and hold it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_diff_sr <= '0;
      r_diff    <= '0;
      r_borrow  <= 1'b0;
      r_cnt     <= '0;
      r_brw     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb   <= 1'b0;
      r_b_msb   <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a_sr    <= a;
      r_b_sr    <= b;
      r_diff_sr <= '0;
      r_cnt     <= '0;
      r_brw     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb   <= a[WIDTH-1];
      r_b_msb   <= b[WIDTH-1];
`endif
    end else if (w_shift) begin
      r_a_sr    <= r_a_sr >> 1;
      r_b_sr    <= r_b_sr >> 1;
      r_diff_sr <= w_diff_nx[WIDTH-1:1];
      r_brw     <= w_nb;
      r_cnt     <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff   <= w_diff_nx;
        r_borrow <= w_nb;
`ifdef SERIAL_SUB_OVF_EN
        // The last bit produced is the result MSB.
        r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
      end
    end
  end

  assign diff        = r_diff;
  assign borrow_out  = r_borrow;
  assign o_dbg_state = r_state;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf         = r_ovf;
`endif

endmodule
